uart_tx_cfg: RTL and testbench

//   Parametrised UART transmitter, successor to the fixed 8N1 TX. Serialises one word
//   per valid/ready handshake: start bit, DATA_BITS data bits (LSB first), optional

---
 rtl/uart_tx_cfg_if.sv | 12 +
 rtl/uart_tx_cfg.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Word handshake between the framer and the UART transmitter.
// Master drives the word and its valid; the transmitter returns ready.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter: start, DATA_BITS data (LSB first), optional parity, 1 or 2 stop bits per word.
// Each bit lasts OVERSAMPLE s_ticks; define UART_TX_BREAK_EN to add the tx_break line-break input.
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_tick,
    uart_tx_cfg_if.slave bus,
    input  logic [1:0]  cfg_parity,
    input  logic        cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic        tx_break,
`endif
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_done
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS=%0d outside 5..9", DATA_BITS);
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_oversample
        $error("uart_tx_cfg: OVERSAMPLE=%0d outside 4..64", OVERSAMPLE);
    end

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
        , BREAK, BRK_REC
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_idx, bit_nxt;
    logic [DATA_BITS-1:0] shreg, sh_nxt;
    logic                 par_bit, par_nxt;
    logic                 par_en, paren_nxt;
    logic                 stop2, stop2_nxt;
    logic                 stop_idx, stop_nxt;
    logic                 tx_nxt, busy_nxt, done_nxt;
    logic                 ready, accept, wrap;

`ifdef UART_TX_BREAK_EN
    assign ready = (state == IDLE) && !tx_break;
`else
    assign ready = (state == IDLE);
`endif
    assign bus.tx_ready = ready;
    assign accept       = bus.tx_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_en   <= 1'b0;
            stop2    <= 1'b0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_idx  <= bit_nxt;
            shreg    <= sh_nxt;
            par_bit  <= par_nxt;
            par_en   <= paren_nxt;
            stop2    <= stop2_nxt;
            stop_idx <= stop_nxt;
            tx       <= tx_nxt;
            tx_busy  <= busy_nxt;
            tx_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        par_nxt   = par_bit;
        paren_nxt = par_en;
        stop2_nxt = stop2;
        stop_nxt  = stop_idx;
        tx_nxt    = tx;
        busy_nxt  = tx_busy;
        done_nxt  = 1'b0;
        wrap      = s_tick && (tick_cnt == TICK_LAST);

        // Every wrap is a bit boundary, so the counter restarts from zero there.
        if (state != IDLE && s_tick)
            tick_nxt = wrap ? '0 : tick_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    sh_nxt    = bus.tx_data;
                    par_nxt   = (cfg_parity == 2'b01) ? ~(^bus.tx_data) : ^bus.tx_data;
                    paren_nxt = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                    stop2_nxt = cfg_stop2;
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    stop_nxt  = 1'b0;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = START;
                end
`ifdef UART_TX_BREAK_EN
                else if (tx_break) begin
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = BREAK;
                end
`endif
            end
            START: begin
                if (wrap) begin
                    tx_nxt    = shreg[0];
                    sh_nxt    = shreg >> 1;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_idx == BIT_LAST) begin
                        stop_nxt  = 1'b0;
                        tx_nxt    = par_en ? par_bit : 1'b1;
                        state_nxt = par_en ? PARITY : STOP;
                    end else begin
                        tx_nxt  = shreg[0];
                        sh_nxt  = shreg >> 1;
                        bit_nxt = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (wrap) begin
                    tx_nxt    = 1'b1;
                    stop_nxt  = 1'b0;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    if (stop2 && !stop_idx) begin
                        stop_nxt = 1'b1;
                    end else begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (!tx_break) begin
                    tx_nxt    = 1'b1;
                    tick_nxt  = '0;
                    state_nxt = BRK_REC;
                end
            end
            // Guaranteed idle-high bit period after a break before new words are taken.
            BRK_REC: begin
                if (wrap) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg (8 data bits, 16x oversample): expected frames are queued at
// stimulus time and a negedge monitor checks every tick sample of each completed frame.
module tb_uart_tx_cfg;
    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] par;
        logic       stop2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic s_tick;
    logic [1:0] cfg_parity;
    logic cfg_stop2;
    logic tx, tx_busy, tx_done;
`ifdef UART_TX_BREAK_EN
    logic tx_break;
`endif

    uart_tx_cfg_if #(.DATA_BITS(8)) bus ();

    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tick     (s_tick),
        .bus        (bus),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
`ifdef UART_TX_BREAK_EN
        .tx_break   (tx_break),
`endif
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int   n_asrt = 0;
    int   n_fail = 0;
    int   n_done = 0;
    exp_t exp_q[$];
    logic samples[$];
    bit   in_frame = 1'b0;
    bit   busy_bad = 1'b0;
    logic prev_done = 1'b0;

    function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // One-clk-wide oversample ticks with an irregular 2..4 clk spacing.
    initial begin
        int gap = 2;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gap == 0) begin
                s_tick = 1'b1;
                gap    = $urandom_range(1, 3);
            end else begin
                s_tick = 1'b0;
                gap--;
            end
        end
    end

    function automatic void finish_frame();
        exp_t e;
        logic bits[$];
        logic obs;
        int   idx;
        check("exp_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(e.data[i]);
        if (e.par == 2'b10) bits.push_back(^e.data);
        else if (e.par == 2'b01) bits.push_back(~(^e.data));
        bits.push_back(1'b1);
        if (e.stop2) bits.push_back(1'b1);
        check($sformatf("frame_ticks_%0h", e.data), 32'(samples.size()), 32'(bits.size() * OS));
        for (int b = 0; b < bits.size(); b++) begin
            obs = bits[b];
            for (int k = 0; k < OS; k++) begin
                idx = b * OS + k;
                if (idx < samples.size() && samples[idx] !== bits[b]) obs = samples[idx];
            end
            check($sformatf("frame_%0h_bit%0d", e.data, b), 32'(obs), 32'(bits[b]));
        end
        check("busy_in_frame", 32'(busy_bad), 0);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            samples.delete();
        end else begin
            if (tx_done) begin
                n_done++;
                check("done_width", 32'(prev_done), 0);
                check("ready_after_done", 32'(bus.tx_ready), 1);
                check("done_in_frame", 32'(in_frame), 1);
                if (in_frame) finish_frame();
                in_frame = 1'b0;
            end else if (in_frame && s_tick) begin
                samples.push_back(tx);
                if (tx_busy !== 1'b1) busy_bad = 1'b1;
            end
            // A tick in the accept cycle belongs to no frame, so start after sampling.
            if (bus.tx_valid && bus.tx_ready) begin
                in_frame = 1'b1;
                busy_bad = 1'b0;
                samples.delete();
            end
        end
        prev_done = tx_done;
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.tx_ready), 1);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] p, input logic s2);
        exp_q.push_back('{data: d, par: p, stop2: s2});
        @(posedge clk);
        #1;
        bus.tx_data = d;
        cfg_parity  = p;
        cfg_stop2   = s2;
        bus.tx_valid = 1'b1;
        wait_ready($sformatf("accept_%0h", d));
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((in_frame || exp_q.size() != 0) && n < 4000);
        check(tag, 32'(in_frame || exp_q.size() != 0), 0);
    endtask

    initial begin
        int d0;
        int n;
        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
`ifdef UART_TX_BREAK_EN
        tx_break     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_ready", 32'(bus.tx_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(8'h55, 2'b00, 1'b0);
        wait_idle("idle_8n1");
        check("idle_tx", 32'(tx), 1);
        check("idle_busy", 32'(tx_busy), 0);

        send(8'hA5, 2'b10, 1'b0);
        wait_idle("idle_even");
        send(8'hA5, 2'b01, 1'b0);
        wait_idle("idle_odd");

        // Config changes mid-frame must not alter the latched framing.
        send(8'hFF, 2'b00, 1'b1);
        repeat (100) @(posedge clk);
        #1;
        cfg_stop2  = 1'b0;
        cfg_parity = 2'b10;
        wait_idle("idle_stop2");

        d0 = n_done;
        exp_q.push_back('{data: 8'h12, par: 2'b00, stop2: 1'b0});
        exp_q.push_back('{data: 8'h34, par: 2'b00, stop2: 1'b0});
        @(posedge clk);
        #1;
        bus.tx_data  = 8'h12;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
        bus.tx_valid = 1'b1;
        wait_ready("b2b_first");
        @(posedge clk);
        #1 bus.tx_data = 8'h34;
        wait_ready("b2b_second");
        check("b2b_no_gap", 32'(tx_done), 1);
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        wait_idle("idle_b2b");
        check("b2b_done_count", 32'(n_done - d0), 2);

        send(8'h3C, 2'b00, 1'b0);
        n = 0;
        while (samples.size() < 70 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach_data_bit3", 32'(samples.size() >= 70), 1);
        d0 = n_done;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 1);
        check("midrst_busy", 32'(tx_busy), 0);
        check("midrst_done", 32'(tx_done), 0);
        check("midrst_ready", 32'(bus.tx_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("midrst_no_done", 32'(n_done - d0), 0);
        send(8'h0F, 2'b00, 1'b0);
        wait_idle("idle_after_rst");

`ifdef UART_TX_BREAK_EN
        @(posedge clk);
        #1 tx_break = 1'b1;
        @(negedge clk);
        n = 0;
        d0 = 0;
        while (n < 40) begin
            @(negedge clk);
            if (tx !== 1'b0 || bus.tx_ready !== 1'b0 || tx_busy !== 1'b1) d0++;
            if (s_tick) n++;
        end
        check("break_line_low", 32'(d0), 0);
        @(posedge clk);
        #1 tx_break = 1'b0;
        @(negedge clk);
        n  = 0;
        d0 = 0;
        for (int c = 0; c < 3000 && !bus.tx_ready; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) d0++;
            if (!bus.tx_ready && s_tick) n++;
        end
        check("break_release_high", 32'(d0), 0);
        check("break_recovery_ticks", 32'(n), OS);
        send(8'hC3, 2'b00, 1'b0);
        wait_idle("idle_after_break");
        check("total_done", 32'(n_done), 8);
`else
        check("total_done", 32'(n_done), 7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
